// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with per-key debounce and a three-digit decimal entry.
// Digits build up a pending number; enter converts it to an 8-bit value, or flags err when it exceeds 255.
//
// state   | meaning
// IDLE    | no key accepted; waiting for a scan with exactly one key down
// PRESS   | candidate key seen; counting agreeing scans before accepting it
// HELD    | key accepted and press emitted; waiting for an empty scan
// RELEASE | empty scans seen; counting them before re-arming
module keypad_entry #(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [7:0] value,
  output logic       value_valid,
  output logic [9:0] pending,
  output logic [1:0] digits,
  output logic       err
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [SW-1:0] STAB_DONE = SW'(DEBOUNCE_SCANS);
  localparam logic [3:0] CODE_CLEAR = 4'd12;
  localparam logic [3:0] CODE_ENTER = 4'd14;

  typedef enum logic [1:0] {IDLE, PRESS, HELD, RELEASE} state_t;

  logic [CW-1:0] cnt;
  logic [1:0]    row_idx;
  logic [1:0]    acc_cnt;
  logic [3:0]    acc_code;
  logic [2:0]    low_cnt;
  logic [1:0]    low_pos;
  logic [2:0]    sum_cnt;
  logic [1:0]    scan_cnt;
  logic [3:0]    scan_code;
  logic          sample;
  logic          scan_end;
  logic          key_valid;

  state_t        state;
  logic [3:0]    cand;
  logic [SW-1:0] stab;
  logic [SW-1:0] stab_inc;
  logic          press_vld;
  logic [3:0]    press_code;
  logic          is_digit;
  logic [3:0]    digit;

  // Key code is {row, col}; the scan result counts low keys, saturating at two.
  always_comb begin
    low_cnt = 3'd0;
    low_pos = 2'd0;
    for (int c = 0; c < 4; c++) begin
      if (!col[c]) begin
        low_cnt = low_cnt + 3'd1;
        low_pos = 2'(c);
      end
    end
    sum_cnt   = {1'b0, acc_cnt} + low_cnt;
    scan_cnt  = (sum_cnt >= 3'd2) ? 2'd2 : sum_cnt[1:0];
    scan_code = (low_cnt == 3'd1) ? {row_idx, low_pos} : acc_code;
  end

  assign sample    = (cnt == CNT_LAST);
  assign scan_end  = sample && (row_idx == 2'd3);
  assign key_valid = (scan_cnt == 2'd1);
  assign stab_inc  = stab + STAB_ONE;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt      <= '0;
      row_idx  <= 2'd0;
      row      <= 4'b1110;
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      cnt     <= '0;
      row_idx <= row_idx + 2'd1;
      row     <= ~(4'b0001 << (row_idx + 2'd1));
      if (scan_end) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_cnt  <= scan_cnt;
        acc_code <= scan_code;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cand       <= 4'd0;
      stab       <= '0;
      press_vld  <= 1'b0;
      press_code <= 4'd0;
    end else begin
      press_vld <= 1'b0;
      if (scan_end) begin
        case (state)
          IDLE: if (key_valid) begin
            cand <= scan_code;
            stab <= STAB_ONE;
            if (STAB_ONE == STAB_DONE) begin
              state      <= HELD;
              press_vld  <= 1'b1;
              press_code <= scan_code;
            end else begin
              state <= PRESS;
            end
          end
          PRESS: if (key_valid && scan_code == cand) begin
            if (stab_inc == STAB_DONE) begin
              state      <= HELD;
              press_vld  <= 1'b1;
              press_code <= cand;
            end else begin
              stab <= stab_inc;
            end
          end else begin
            state <= IDLE;
          end
          HELD: if (!key_valid) begin
            stab  <= STAB_ONE;
            state <= (STAB_ONE == STAB_DONE) ? IDLE : RELEASE;
          end
          RELEASE: if (!key_valid) begin
            if (stab_inc == STAB_DONE) state <= IDLE;
            else stab <= stab_inc;
          end else begin
            state <= HELD;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_comb begin
    is_digit = 1'b1;
    digit    = 4'd0;
    case (press_code)
      4'd0:  digit = 4'd1;
      4'd1:  digit = 4'd2;
      4'd2:  digit = 4'd3;
      4'd4:  digit = 4'd4;
      4'd5:  digit = 4'd5;
      4'd6:  digit = 4'd6;
      4'd8:  digit = 4'd7;
      4'd9:  digit = 4'd8;
      4'd10: digit = 4'd9;
      4'd13: digit = 4'd0;
      default: is_digit = 1'b0;
    endcase
  end

  // pending stays <= 99 whenever a digit is appended, so the x10 cannot overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      value       <= 8'd0;
      value_valid <= 1'b0;
      pending     <= 10'd0;
      digits      <= 2'd0;
      err         <= 1'b0;
    end else begin
      value_valid <= 1'b0;
      if (press_vld) begin
        if (press_code == CODE_CLEAR) begin
          pending <= 10'd0;
          digits  <= 2'd0;
          err     <= 1'b0;
        end else if (press_code == CODE_ENTER) begin
          if (digits != 2'd0) begin
            if (pending <= 10'd255) begin
              value       <= pending[7:0];
              value_valid <= 1'b1;
              err         <= 1'b0;
            end else begin
              err <= 1'b1;
            end
            pending <= 10'd0;
            digits  <= 2'd0;
          end
        end else if (is_digit && digits != 2'd3) begin
          pending <= (pending << 3) + (pending << 1) + {6'd0, digit};
          digits  <= digits + 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a behavioural key matrix drives col from row,
// and each scenario task checks pending/digits/value/err and value_valid pulses.
module tb_keypad_entry;

  logic       clk;
  logic       rst_n;
  logic [3:0] col;
  logic [3:0] row;
  logic [7:0] value;
  logic       value_valid;
  logic [9:0] pending;
  logic [1:0] digits;
  logic       err;

  logic [15:0] keys;
  int n_tests;
  int n_fail;
  int pulse_cnt;
  int long_cnt;
  logic vv_prev;

  localparam int SCAN = 16;
  localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6;
  localparam int K7 = 8, K8 = 9, K9 = 10, KSTAR = 12, K0 = 13, KHASH = 14;

  keypad_entry #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row), .value(value),
    .value_valid(value_valid), .pending(pending), .digits(digits), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      if (!row[r])
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) col[c] = 1'b0;
  end

  initial begin
    pulse_cnt = 0;
    long_cnt  = 0;
    vv_prev   = 1'b0;
    forever begin
      @(negedge clk);
      if (value_valid) pulse_cnt++;
      if (value_valid && vv_prev) long_cnt++;
      vv_prev = value_valid;
    end
  end

  task automatic press(input int k, input int hold_scans);
    keys = '0;
    keys[k] = 1'b1;
    repeat (hold_scans * SCAN) @(negedge clk);
    keys = '0;
    repeat (3 * SCAN) @(negedge clk);
  endtask

  task automatic test_reset;
    logic [3:0] exp_row [4];
    exp_row[0] = 4'b1101; exp_row[1] = 4'b1011; exp_row[2] = 4'b0111; exp_row[3] = 4'b1110;
    rst_n = 1'b0;
    keys  = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (row !== 4'b1110 || value !== 8'd0 || value_valid !== 1'b0 ||
        pending !== 10'd0 || digits !== 2'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: row=%b value=%0d vv=%b pending=%0d digits=%0d err=%b, required 1110/0/0/0/0/0",
               row, value, value_valid, pending, digits, err);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      n_tests++;
      if (row !== exp_row[i]) begin
        n_fail++;
        $display("FAIL row_step%0d: row=%b required %b", i, row, exp_row[i]);
      end
    end
  endtask

  task automatic test_entry;
    int p0;
    int l0;
    int exp_pend [3];
    int seq [3];
    seq[0] = K1; seq[1] = K2; seq[2] = K8;
    exp_pend[0] = 1; exp_pend[1] = 12; exp_pend[2] = 128;
    for (int i = 0; i < 3; i++) begin
      press(seq[i], 3);
      n_tests++;
      if (pending !== 10'(exp_pend[i]) || digits !== 2'(i + 1)) begin
        n_fail++;
        $display("FAIL entry_digit%0d: pending=%0d digits=%0d required %0d/%0d",
                 i, pending, digits, exp_pend[i], i + 1);
      end
    end
    p0 = pulse_cnt;
    l0 = long_cnt;
    press(KHASH, 3);
    n_tests++;
    if (value !== 8'd128 || err !== 1'b0 || pending !== 10'd0 || digits !== 2'd0) begin
      n_fail++;
      $display("FAIL entry_enter: value=%0d err=%b pending=%0d digits=%0d required 128/0/0/0",
               value, err, pending, digits);
    end
    n_tests++;
    if (pulse_cnt - p0 != 1 || long_cnt != l0) begin
      n_fail++;
      $display("FAIL entry_pulse: pulses=%0d long=%0d required 1/0", pulse_cnt - p0, long_cnt - l0);
    end
  endtask

  task automatic test_overflow;
    int p0;
    p0 = pulse_cnt;
    press(K3, 3);
    press(K0, 3);
    press(K0, 3);
    n_tests++;
    if (pending !== 10'd300 || digits !== 2'd3) begin
      n_fail++;
      $display("FAIL ovf_pending: pending=%0d digits=%0d required 300/3", pending, digits);
    end
    press(KHASH, 3);
    n_tests++;
    if (err !== 1'b1 || value !== 8'd128 || pending !== 10'd0 || digits !== 2'd0 || pulse_cnt != p0) begin
      n_fail++;
      $display("FAIL ovf_enter: err=%b value=%0d pending=%0d digits=%0d pulses=%0d required 1/128/0/0/0",
               err, value, pending, digits, pulse_cnt - p0);
    end
    press(KSTAR, 3);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: err=%b required 0", err);
    end
    p0 = pulse_cnt;
    press(KHASH, 3);
    n_tests++;
    if (pulse_cnt != p0 || value !== 8'd128 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_enter: pulses=%0d value=%0d err=%b required 0/128/0", pulse_cnt - p0, value, err);
    end
  endtask

  task automatic test_hold;
    press(K5, 10);
    n_tests++;
    if (pending !== 10'd5 || digits !== 2'd1) begin
      n_fail++;
      $display("FAIL hold_once: pending=%0d digits=%0d required 5/1", pending, digits);
    end
  endtask

  task automatic test_bounce;
    press(K7, 1);
    n_tests++;
    if (pending !== 10'd5 || digits !== 2'd1) begin
      n_fail++;
      $display("FAIL bounce: pending=%0d digits=%0d required 5/1", pending, digits);
    end
  endtask

  task automatic test_two_keys;
    keys = '0;
    keys[K1] = 1'b1;
    keys[K6] = 1'b1;
    repeat (4 * SCAN) @(negedge clk);
    keys = '0;
    repeat (3 * SCAN) @(negedge clk);
    n_tests++;
    if (pending !== 10'd5 || digits !== 2'd1) begin
      n_fail++;
      $display("FAIL two_keys: pending=%0d digits=%0d required 5/1", pending, digits);
    end
  endtask

  task automatic test_max_digits;
    press(KSTAR, 3);
    press(K9, 3);
    press(K9, 3);
    press(K9, 3);
    press(K4, 3);
    n_tests++;
    if (pending !== 10'd999 || digits !== 2'd3) begin
      n_fail++;
      $display("FAIL max_digits: pending=%0d digits=%0d required 999/3", pending, digits);
    end
    press(KA, 3);
    n_tests++;
    if (pending !== 10'd999 || digits !== 2'd3) begin
      n_fail++;
      $display("FAIL letter_key: pending=%0d digits=%0d required 999/3", pending, digits);
    end
  endtask

  task automatic test_reset_mid_debounce;
    keys = '0;
    keys[K2] = 1'b1;
    repeat (SCAN) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (row !== 4'b1110 || value !== 8'd0 || value_valid !== 1'b0 ||
        pending !== 10'd0 || digits !== 2'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: row=%b value=%0d vv=%b pending=%0d digits=%0d err=%b, required 1110/0/0/0/0/0",
               row, value, value_valid, pending, digits, err);
    end
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_tests++;
    if (pending !== 10'd0 || digits !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_one_scan: pending=%0d digits=%0d required 0/0", pending, digits);
    end
    repeat (16) @(negedge clk);
    n_tests++;
    if (pending !== 10'd2 || digits !== 2'd1) begin
      n_fail++;
      $display("FAIL reset_repress: pending=%0d digits=%0d required 2/1", pending, digits);
    end
    keys = '0;
    repeat (3 * SCAN) @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    keys    = '0;
    rst_n   = 1'b0;
    test_reset();
    test_entry();
    test_overflow();
    test_hold();
    test_bounce();
    test_two_keys();
    test_max_digits();
    test_reset_mid_debounce();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
